// File: rtl/vend_credit_changer.sv
// ---------------------------------------------------------------------------
// vend_credit_changer
//
// Sequential credit/change controller for the vending-machine datapath.
// Accumulates coin credit, checks a keypad selection against a price table,
// emits a one-cycle vend pulse and then pays the remaining credit back as
// change, greedily, one coin per dispenser handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (discards all credit)
//   coin_valid    a coin was inserted this cycle
//   coin_value    value of the inserted coin
//   sel_valid     item selection request
//   sel_item      selected item index
//   cancel        refund request (honoured while collecting credit)
//   change_ready  coin dispenser accepts the offered change coin
//   vend_valid    one-cycle vend pulse
//   vend_item     item being vended (meaningful with vend_valid)
//   change_valid  a change coin is being offered
//   change_coin   denomination of the offered change coin
//   coin_reject   one-cycle pulse: inserted coin returned, not credited
//   sel_deny      one-cycle pulse: selection refused
//   credit        current credit
//   busy          high while vending or paying change
// ---------------------------------------------------------------------------
module vend_credit_changer #(
  parameter int CREDIT_W  = 6,
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {6'd1, 6'd2, 6'd3, 6'd4},
  parameter logic [CREDIT_W-1:0] DENOM_HI  = 6'd5,
  parameter logic [CREDIT_W-1:0] DENOM_MID = 6'd2,
  parameter logic [CREDIT_W-1:0] DENOM_LO  = 6'd1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_item,
  input  logic                cancel,
  input  logic                change_ready,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_item,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_coin,
  output logic                coin_reject,
  output logic                sel_deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  state_t              state_reg;
  logic                vend_valid_reg;
  logic [SEL_W-1:0]    vend_item_reg;
  logic                change_valid_reg;
  logic [CREDIT_W-1:0] change_coin_reg;
  logic                coin_reject_reg;
  logic                sel_deny_reg;
  logic [CREDIT_W-1:0] credit_reg;
  logic                busy_reg;

  // -------------------------------------------------------------------------
  // Price table unpacked from the flat parameter, one entry per item.
  // -------------------------------------------------------------------------
  logic [CREDIT_W-1:0] price_table [NUM_ITEMS];

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
    assign price_table[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
  end

  // Largest change denomination not exceeding the amount still owed.
  function automatic logic [CREDIT_W-1:0] pick_coin(input logic [CREDIT_W-1:0] amount);
    if (amount >= DENOM_HI) begin
      return DENOM_HI;
    end else if (amount >= DENOM_MID) begin
      return DENOM_MID;
    end else if (amount >= DENOM_LO) begin
      return DENOM_LO;
    end
    return '0;
  endfunction

  // -------------------------------------------------------------------------
  // Datapath helpers, all derived from the current registered credit.
  // -------------------------------------------------------------------------
  logic                sel_in_range;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_affordable;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic                coin_nonzero;
  logic [CREDIT_W-1:0] credit_after_pay;
  logic [CREDIT_W-1:0] offer_now;
  logic [CREDIT_W-1:0] offer_after_pay;

  assign sel_in_range   = int'(sel_item) < NUM_ITEMS;
  assign sel_price      = sel_in_range ? price_table[sel_item] : '0;
  // Affordability uses the credit held before any same-cycle coin.
  assign sel_affordable = sel_in_range && (credit_reg >= sel_price);

  // One extra bit catches a coin that would wrap the credit register.
  assign coin_sum     = {1'b0, credit_reg} + {1'b0, coin_value};
  assign coin_fits    = ~coin_sum[CREDIT_W];
  assign coin_nonzero = |coin_value;

  assign credit_after_pay = credit_reg - change_coin_reg;
  assign offer_now        = pick_coin(credit_reg);
  assign offer_after_pay  = pick_coin(credit_after_pay);

  // -------------------------------------------------------------------------
  // Controller: state and every output are registered here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      vend_valid_reg   <= 1'b0;
      vend_item_reg    <= '0;
      change_valid_reg <= 1'b0;
      change_coin_reg  <= '0;
      coin_reject_reg  <= 1'b0;
      sel_deny_reg     <= 1'b0;
      credit_reg       <= '0;
      busy_reg         <= 1'b0;
    end else begin
      // Pulse outputs default low so they last exactly one cycle.
      vend_valid_reg  <= 1'b0;
      coin_reject_reg <= 1'b0;
      sel_deny_reg    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          // Nothing is ever affordable from zero credit.
          if (sel_valid) begin
            sel_deny_reg <= 1'b1;
          end
          if (coin_valid && coin_nonzero) begin
            if (coin_fits) begin
              credit_reg <= coin_sum[CREDIT_W-1:0];
              state_reg  <= ST_COLLECT;
            end else begin
              coin_reject_reg <= 1'b1;
            end
          end
        end

        ST_COLLECT: begin
          if (cancel) begin
            // Refund wins over everything; a concurrent coin is handed back.
            coin_reject_reg  <= coin_valid;
            state_reg        <= ST_CHANGE;
            busy_reg         <= 1'b1;
            change_valid_reg <= 1'b1;
            change_coin_reg  <= offer_now;
          end else if (sel_valid && sel_affordable) begin
            coin_reject_reg <= coin_valid;
            state_reg       <= ST_VEND;
            busy_reg        <= 1'b1;
            vend_valid_reg  <= 1'b1;
            vend_item_reg   <= sel_item;
            credit_reg      <= credit_reg - sel_price;
          end else begin
            // A denied selection does not block a coin in the same cycle.
            if (sel_valid) begin
              sel_deny_reg <= 1'b1;
            end
            if (coin_valid && coin_nonzero) begin
              if (coin_fits) begin
                credit_reg <= coin_sum[CREDIT_W-1:0];
              end else begin
                coin_reject_reg <= 1'b1;
              end
            end
          end
        end

        ST_VEND: begin
          coin_reject_reg <= coin_valid;
          if (credit_reg != '0) begin
            state_reg        <= ST_CHANGE;
            change_valid_reg <= 1'b1;
            change_coin_reg  <= offer_now;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end

        ST_CHANGE: begin
          coin_reject_reg <= coin_valid;
          // Offer is held until the dispenser takes it, then recomputed
          // from what is still owed.
          if (change_ready) begin
            credit_reg <= credit_after_pay;
            if (credit_after_pay == '0) begin
              state_reg        <= ST_IDLE;
              busy_reg         <= 1'b0;
              change_valid_reg <= 1'b0;
              change_coin_reg  <= '0;
            end else begin
              change_coin_reg <= offer_after_pay;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign vend_valid   = vend_valid_reg;
  assign vend_item    = vend_item_reg;
  assign change_valid = change_valid_reg;
  assign change_coin  = change_coin_reg;
  assign coin_reject  = coin_reject_reg;
  assign sel_deny     = sel_deny_reg;
  assign credit       = credit_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_vend_credit_changer.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_changer
//
// Self-checking bench for vend_credit_changer. A behavioural model tracks the
// credit as a number and the pending change as a queue of coins produced by
// greedy decomposition; DUT outputs are compared every cycle on the falling
// edge, with extra directed checks at notable points of each scenario.
// ---------------------------------------------------------------------------
module tb_vend_credit_changer;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       change_ready;
  logic       vend_valid;
  logic [1:0] vend_item;
  logic       change_valid;
  logic [5:0] change_coin;
  logic       coin_reject;
  logic       sel_deny;
  logic [5:0] credit;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_credit_changer dut (
    .clk          (clk),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .change_ready (change_ready),
    .vend_valid   (vend_valid),
    .vend_item    (vend_item),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .sel_deny     (sel_deny),
    .credit       (credit),
    .busy         (busy)
  );

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  localparam logic [23:0] PRICE_TABLE = {6'd1, 6'd2, 6'd3, 6'd4};

  int m_credit  = 0;
  bit m_vending = 0;
  int m_item    = 0;
  int m_q[$];
  bit e_rej     = 0;
  bit e_deny    = 0;

  function automatic int price_of(input int i);
    logic [23:0] t;
    t = PRICE_TABLE;
    return int'(t[i*6 +: 6]);
  endfunction

  function automatic void build_change(input int amount);
    int c;
    m_q.delete();
    while (amount > 0) begin
      if (amount >= 5) c = 5;
      else if (amount >= 2) c = 2;
      else c = 1;
      m_q.push_back(c);
      amount -= c;
    end
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    e_rej  = 0;
    e_deny = 0;
    if (reset) begin
      m_credit  = 0;
      m_vending = 0;
      m_item    = 0;
      m_q.delete();
    end else if (m_vending) begin
      e_rej     = coin_valid;
      m_vending = 0;
      build_change(m_credit);
    end else if (m_q.size() > 0) begin
      e_rej = coin_valid;
      if (change_ready) m_credit -= m_q.pop_front();
    end else if (m_credit == 0) begin
      e_deny = sel_valid;
      if (coin_valid && coin_value != 0) m_credit = int'(coin_value);
    end else begin
      if (cancel) begin
        e_rej = coin_valid;
        build_change(m_credit);
      end else if (sel_valid && m_credit >= price_of(int'(sel_item))) begin
        m_credit -= price_of(int'(sel_item));
        m_vending = 1;
        m_item    = int'(sel_item);
        e_rej     = coin_valid;
      end else begin
        e_deny = sel_valid;
        if (coin_valid && coin_value != 0) begin
          if (m_credit + int'(coin_value) <= 63) m_credit += int'(coin_value);
          else e_rej = 1;
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_vec();
    logic [5:0] cc;
    logic       pending;
    pending = m_q.size() > 0;
    cc = pending ? 6'(m_q[0]) : 6'd0;
    return {m_vending, m_vending ? 2'(m_item) : 2'd0, pending, cc,
            e_rej, e_deny, 6'(m_credit), m_vending | pending};
  endfunction

  function automatic logic [18:0] obs_vec();
    return {vend_valid, vend_valid ? vend_item : 2'd0, change_valid,
            change_valid ? change_coin : 6'd0, coin_reject, sel_deny, credit, busy};
  endfunction

  // Stimulus word: {reset, coin_valid, coin_value[5:0], sel_valid, sel_item[1:0], cancel, change_ready}
  function automatic logic [12:0] st(input bit r, input bit cv, input int cval,
                                     input bit sv, input int si, input bit can, input bit rdy);
    return {r, cv, 6'(cval), sv, 2'(si), can, rdy};
  endfunction

  task automatic drive_word(input logic [12:0] w);
    reset        = w[12];
    coin_valid   = w[11];
    coin_value   = w[10:5];
    sel_valid    = w[4];
    sel_item     = w[3:2];
    cancel       = w[1];
    change_ready = w[0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------------
  // Scenarios
  // ------------------------------------------------------------------------
  task automatic test_reset();
    logic [12:0] s[$];
    s.push_back(st(1, 1, 9, 1, 2, 1, 1));
    s.push_back(st(1, 0, 0, 0, 0, 0, 0));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL reset step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      total++;
      if ({vend_valid, vend_item, change_valid, change_coin, coin_reject, sel_deny, credit, busy} !== 19'd0) begin
        bad++;
        $display("FAIL reset_zero step %0d: got %h want 0", k,
                 {vend_valid, vend_item, change_valid, change_coin, coin_reject, sel_deny, credit, busy});
      end
    end
  endtask

  task automatic test_vend_change();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 1, 4, 0, 0, 0, 1));
    s.push_back(st(0, 1, 4, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 1, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL vend_change step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 3) begin
        total++;
        if ({vend_valid, vend_item, credit, busy} !== {1'b1, 2'd0, 6'd4, 1'b1}) begin
          bad++;
          $display("FAIL vend_pulse: got v=%0b i=%0d c=%0d b=%0b want v=1 i=0 c=4 b=1",
                   vend_valid, vend_item, credit, busy);
        end
      end
      if (k == 4 || k == 5) begin
        total++;
        if ({vend_valid, change_valid, change_coin} !== {1'b0, 1'b1, 6'd2}) begin
          bad++;
          $display("FAIL vend_change_coin step %0d: got v=%0b cv=%0b coin=%0d want v=0 cv=1 coin=2",
                   k, vend_valid, change_valid, change_coin);
        end
      end
      if (k == 6) begin
        total++;
        if ({change_valid, credit, busy} !== {1'b0, 6'd0, 1'b0}) begin
          bad++;
          $display("FAIL vend_change_end: got cv=%0b c=%0d b=%0b want 0 0 0", change_valid, credit, busy);
        end
      end
    end
  endtask

  task automatic test_deny_cancel();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 1, 2, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 1, 1, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 1, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL deny_cancel step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 2) begin
        total++;
        if ({sel_deny, vend_valid, credit} !== {1'b1, 1'b0, 6'd2}) begin
          bad++;
          $display("FAIL deny_pulse: got d=%0b v=%0b c=%0d want d=1 v=0 c=2", sel_deny, vend_valid, credit);
        end
      end
      if (k == 4) begin
        total++;
        if ({change_valid, change_coin, vend_valid} !== {1'b1, 6'd2, 1'b0}) begin
          bad++;
          $display("FAIL cancel_coin: got cv=%0b coin=%0d v=%0b want cv=1 coin=2 v=0",
                   change_valid, change_coin, vend_valid);
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 1, 60, 0, 0, 0, 1));
    s.push_back(st(0, 1, 5, 0, 0, 0, 1));
    s.push_back(st(0, 1, 3, 0, 0, 0, 1));
    s.push_back(st(0, 1, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 1, 1));
    for (int i = 0; i < 16; i++) s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL overflow step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 2) begin
        total++;
        if ({coin_reject, credit} !== {1'b1, 6'd60}) begin
          bad++;
          $display("FAIL overflow_reject: got r=%0b c=%0d want r=1 c=60", coin_reject, credit);
        end
      end
      if (k == 3 || k == 4) begin
        total++;
        if ({coin_reject, credit} !== {1'b0, 6'd63}) begin
          bad++;
          $display("FAIL overflow_fill step %0d: got r=%0b c=%0d want r=0 c=63", k, coin_reject, credit);
        end
      end
    end
  endtask

  task automatic test_change_stall();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 1, 7, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL stall step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k >= 2 && k <= 5) begin
        total++;
        if ({change_valid, change_coin, credit} !== {1'b1, 6'd5, 6'd7}) begin
          bad++;
          $display("FAIL stall_hold step %0d: got cv=%0b coin=%0d c=%0d want 1 5 7",
                   k, change_valid, change_coin, credit);
        end
      end
    end
  endtask

  task automatic test_change_coin_reset();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 0));
    s.push_back(st(0, 1, 7, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 1, 0));
    s.push_back(st(0, 1, 3, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(1, 1, 4, 1, 0, 1, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL change_reset step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 3) begin
        total++;
        if ({coin_reject, credit} !== {1'b1, 6'd7}) begin
          bad++;
          $display("FAIL change_coin_reject: got r=%0b c=%0d want r=1 c=7", coin_reject, credit);
        end
      end
      if (k == 5) begin
        total++;
        if ({vend_valid, vend_item, change_valid, change_coin, coin_reject, sel_deny, credit, busy} !== 19'd0) begin
          bad++;
          $display("FAIL midchange_reset: got %h want 0",
                   {vend_valid, vend_item, change_valid, change_coin, coin_reject, sel_deny, credit, busy});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] s[$];
    s.push_back(st(1, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 1, 4, 0, 0, 0, 1));
    s.push_back(st(0, 1, 1, 1, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 1, 2, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 1, 3, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 0, 0, 1));
    foreach (s[k]) begin
      drive_word(s[k]);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL back_to_back step %0d: got %h want %h", k, obs_vec(), exp_vec());
      end
      if (k == 2) begin
        total++;
        if ({vend_valid, vend_item, coin_reject, credit} !== {1'b1, 2'd0, 1'b1, 6'd0}) begin
          bad++;
          $display("FAIL sel_beats_coin: got v=%0b i=%0d r=%0b c=%0d want 1 0 1 0",
                   vend_valid, vend_item, coin_reject, credit);
        end
      end
      if (k == 3) begin
        total++;
        if ({vend_valid, change_valid, busy, credit} !== {1'b0, 1'b0, 1'b0, 6'd0}) begin
          bad++;
          $display("FAIL vend_to_idle: got v=%0b cv=%0b b=%0b c=%0d want 0 0 0 0",
                   vend_valid, change_valid, busy, credit);
        end
      end
    end
  endtask

  task automatic test_random();
    int fails_shown = 0;
    bit model_busy;
    for (int n = 0; n < 3000; n++) begin
      model_busy = m_vending || (m_q.size() > 0);
      reset        = ($urandom_range(0, 199) == 0);
      coin_valid   = ($urandom_range(0, 99) < 30);
      coin_value   = 6'($urandom_range(1, 63));
      sel_valid    = !model_busy && ($urandom_range(0, 99) < 20);
      sel_item     = 2'($urandom_range(0, 3));
      cancel       = ($urandom_range(0, 99) < 5);
      change_ready = ($urandom_range(0, 99) < 60);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        if (fails_shown < 20) begin
          fails_shown++;
          $display("FAIL random cycle %0d: got %h want %h", n, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    drive_word(13'd0);
    reset = 1'b1;
    test_reset();
    test_vend_change();
    test_deny_cancel();
    test_overflow();
    test_change_stall();
    test_change_coin_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
